// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl
// Owns every non-sequential update of the program-counter register:
//   - fetches the reset vector at boot and loads it into the PC,
//   - forwards execute-stage branch redirects while running,
//   - accepts NMI/IRQ at instruction boundaries, fetches the matching
//     vector and redirects the PC, capturing the return address.
// Vector bytes are read little-endian (low byte at base, high at base+1)
// through a simple request/ack read port.
module pc_seq_ctrl #(
   parameter int unsigned       ADDR_W    = 16,
   parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(16'hFFFC),
   parameter logic [ADDR_W-1:0] NMI_VEC   = ADDR_W'(16'hFFFA),
   parameter logic [ADDR_W-1:0] IRQ_VEC   = ADDR_W'(16'hFFFE)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc_i,
   input  logic              instr_boundary_i,
   input  logic              branch_req_i,
   input  logic [ADDR_W-1:0] branch_target_i,
   input  logic              nmi_i,
   input  logic              irq_i,
   input  logic              irq_mask_i,
   output logic              vec_req_o,
   output logic [ADDR_W-1:0] vec_addr_o,
   input  logic [7:0]        vec_data_i,
   input  logic              vec_ack_i,
   output logic              load_pc_o,
   output logic [ADDR_W-1:0] load_addr_o,
   output logic              fetch_en_o,
   output logic              int_ack_o,
   output logic              int_src_o,
   output logic [ADDR_W-1:0] ret_pc_o
);

   typedef enum logic [2:0] {
      ST_BOOT   = 3'd0,
      ST_VEC_LO = 3'd1,
      ST_VEC_HI = 3'd2,
      ST_LOAD   = 3'd3,
      ST_RUN    = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      SEL_RESET = 2'd0,
      SEL_NMI   = 2'd1,
      SEL_IRQ   = 2'd2
   } vec_sel_t;

   state_t            r_state;
   vec_sel_t          r_vec_sel;
   logic              r_nmi_prev;
   logic              r_nmi_pending;
   logic [ADDR_W-1:0] r_ret_pc;
   logic [7:0]        r_vec_lo;
   logic [7:0]        r_vec_hi;

   logic              w_nmi_edge;
   logic              w_irq_req;
   logic              w_accept;
   logic              w_accept_nmi;
   logic [ADDR_W-1:0] w_base;
   logic [ADDR_W-1:0] w_vec_word;

   // An interrupt is only taken while running, on a retiring instruction;
   // a pending NMI always beats an unmasked IRQ.
   assign w_nmi_edge   = nmi_i & ~r_nmi_prev;
   assign w_irq_req    = irq_i & ~irq_mask_i;
   assign w_accept     = (r_state == ST_RUN) & instr_boundary_i & (r_nmi_pending | w_irq_req);
   assign w_accept_nmi = w_accept & r_nmi_pending;
   assign w_vec_word   = ADDR_W'({r_vec_hi, r_vec_lo});
   assign ret_pc_o     = r_ret_pc;

   // Select the low-byte address of the vector currently being fetched.
   always_comb begin
      w_base = RESET_VEC;
      case (r_vec_sel)
         SEL_NMI: w_base = NMI_VEC;
         SEL_IRQ: w_base = IRQ_VEC;
         default: w_base = RESET_VEC;
      endcase
   end

   // NMI edge detector; a new edge wins over the clear on acceptance so an
   // edge arriving in the acceptance cycle is not lost. Edges seen in BOOT
   // are ignored because the boot sequence always starts from reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_nmi_prev    <= 1'b0;
         r_nmi_pending <= 1'b0;
      end else begin
         r_nmi_prev <= nmi_i;
         if (w_nmi_edge && (r_state != ST_BOOT)) begin
            r_nmi_pending <= 1'b1;
         end else if (w_accept_nmi) begin
            r_nmi_pending <= 1'b0;
         end
      end
   end

   // Sequencer: boot / vector fetch / PC load / run, plus capture of the
   // vector bytes, the vector source and the interrupt return address.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_BOOT;
         r_vec_sel <= SEL_RESET;
         r_ret_pc  <= '0;
         r_vec_lo  <= 8'h00;
         r_vec_hi  <= 8'h00;
      end else begin
         unique case (r_state)
            ST_BOOT: begin
               r_state <= ST_VEC_LO;
            end
            ST_VEC_LO: begin
               if (vec_ack_i) begin
                  r_vec_lo <= vec_data_i;
                  r_state  <= ST_VEC_HI;
               end
            end
            ST_VEC_HI: begin
               if (vec_ack_i) begin
                  r_vec_hi <= vec_data_i;
                  r_state  <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               r_state <= ST_RUN;
            end
            ST_RUN: begin
               if (w_accept) begin
                  r_vec_sel <= w_accept_nmi ? SEL_NMI : SEL_IRQ;
                  // A branch retiring with the boundary is where the core
                  // would have gone next, so that is the return address.
                  r_ret_pc  <= branch_req_i ? branch_target_i : pc_i;
                  r_state   <= ST_VEC_LO;
               end
            end
            default: begin
               r_state <= ST_BOOT;
            end
         endcase
      end
   end

   // Output decode from state; branch redirects pass straight through in RUN.
   always_comb begin
      fetch_en_o  = 1'b0;
      vec_req_o   = 1'b0;
      vec_addr_o  = '0;
      load_pc_o   = 1'b0;
      load_addr_o = '0;
      int_ack_o   = 1'b0;
      int_src_o   = 1'b0;
      case (r_state)
         ST_VEC_LO: begin
            vec_req_o  = 1'b1;
            vec_addr_o = w_base;
         end
         ST_VEC_HI: begin
            vec_req_o  = 1'b1;
            vec_addr_o = w_base + ADDR_W'(1);
         end
         ST_LOAD: begin
            load_pc_o   = 1'b1;
            load_addr_o = w_vec_word;
            int_ack_o   = (r_vec_sel != SEL_RESET);
            int_src_o   = (r_vec_sel == SEL_NMI);
         end
         ST_RUN: begin
            fetch_en_o  = 1'b1;
            load_pc_o   = branch_req_i;
            load_addr_o = branch_target_i;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// tb_pc_seq_ctrl
// Directed scenarios for boot, branch, NMI, masked IRQ, NMI/IRQ collision
// and reset during a vector fetch, followed by a randomized run checked
// against a transaction-level reference model of the sequencer rules.
`timescale 1ns/1ps
module tb_pc_seq_ctrl;

   logic        clk;
   logic        rst;
   logic [15:0] pc_i;
   logic        instr_boundary_i;
   logic        branch_req_i;
   logic [15:0] branch_target_i;
   logic        nmi_i;
   logic        irq_i;
   logic        irq_mask_i;
   logic        vec_req_o;
   logic [15:0] vec_addr_o;
   logic [7:0]  vec_data_i;
   logic        vec_ack_i;
   logic        load_pc_o;
   logic [15:0] load_addr_o;
   logic        fetch_en_o;
   logic        int_ack_o;
   logic        int_src_o;
   logic [15:0] ret_pc_o;

   int tests_run    = 0;
   int tests_failed = 0;

   // Vector memory: index 0..5 maps to 0xFFFA..0xFFFF.
   logic [7:0] vmem [0:5];
   int         ack_delay  = 1;
   bit         rand_delay = 0;

   pc_seq_ctrl dut (
      .clk              (clk),
      .rst              (rst),
      .pc_i             (pc_i),
      .instr_boundary_i (instr_boundary_i),
      .branch_req_i     (branch_req_i),
      .branch_target_i  (branch_target_i),
      .nmi_i            (nmi_i),
      .irq_i            (irq_i),
      .irq_mask_i       (irq_mask_i),
      .vec_req_o        (vec_req_o),
      .vec_addr_o       (vec_addr_o),
      .vec_data_i       (vec_data_i),
      .vec_ack_i        (vec_ack_i),
      .load_pc_o        (load_pc_o),
      .load_addr_o      (load_addr_o),
      .fetch_en_o       (fetch_en_o),
      .int_ack_o        (int_ack_o),
      .int_src_o        (int_src_o),
      .ret_pc_o         (ret_pc_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] mem_byte(input logic [15:0] a);
      int idx;
      idx = int'(a) - 'hFFFA;
      if (idx >= 0 && idx <= 5) return vmem[idx];
      return 8'hEE;
   endfunction

   // Memory responder: acks each byte request after ack_delay wait cycles
   // (or a random 0..2 in random mode); data is junk except on ack.
   initial begin : responder
      int cnt;
      int cur;
      cnt = 0;
      cur = 1;
      vec_ack_i  = 1'b0;
      vec_data_i = 8'h00;
      forever begin
         @(posedge clk);
         #1;
         if (!vec_req_o) begin
            vec_ack_i  = 1'b0;
            vec_data_i = 8'($urandom);
            cnt = 0;
            cur = rand_delay ? int'($urandom_range(0, 2)) : ack_delay;
         end else if (cnt >= cur) begin
            vec_ack_i  = 1'b1;
            vec_data_i = mem_byte(vec_addr_o);
            cnt = 0;
            cur = rand_delay ? int'($urandom_range(0, 2)) : ack_delay;
         end else begin
            vec_ack_i  = 1'b0;
            vec_data_i = 8'($urandom);
            cnt++;
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: time limit reached, tests_run=%0d", tests_run);
      $fatal(1, "watchdog expired");
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      instr_boundary_i = 1'b0;
      branch_req_i     = 1'b0;
      branch_target_i  = 16'h0000;
      irq_i            = 1'b0;
      irq_mask_i       = 1'b0;
   endtask

   // Observe negedges until a PC load appears or the budget runs out,
   // recording the two vector byte addresses seen on the read port.
   task automatic watch_fetch(input int budget, output bit got,
                              output logic [15:0] a_lo, output logic [15:0] a_hi,
                              output logic [15:0] l_addr, output logic ack,
                              output logic src, output bit fe_seen, output int cycles);
      got = 0; a_lo = 16'h0; a_hi = 16'h0; l_addr = 16'h0;
      ack = 1'b0; src = 1'b0; fe_seen = 0; cycles = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         cycles = i;
         if (vec_req_o) begin
            if (a_lo == 16'h0) a_lo = vec_addr_o;
            else if (a_hi == 16'h0 && vec_addr_o != a_lo) a_hi = vec_addr_o;
         end
         if (load_pc_o) begin
            got = 1; l_addr = load_addr_o; ack = int_ack_o; src = int_src_o;
            return;
         end
         if (fetch_en_o) fe_seen = 1;
      end
   endtask

   task automatic test_reset();
      logic [52:0] obs;
      rst = 1'b1;
      nmi_i = 1'b0;
      for (int i = 0; i < 6; i++) vmem[i] = 8'h00;
      for (int i = 0; i < 10; i++) begin
         pc_i = 16'($urandom); instr_boundary_i = 1'b1; branch_req_i = 1'b1;
         branch_target_i = 16'($urandom); irq_i = 1'b1; irq_mask_i = 1'b0;
         nmi_i = 1'($urandom);
         @(negedge clk);
         obs = {fetch_en_o, vec_req_o, vec_addr_o, load_pc_o, load_addr_o, int_ack_o, int_src_o, ret_pc_o};
         tests_run++;
         if (obs !== 53'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs cycle %0d: got %h required 0", i, obs);
         end
         $display("[TB] reset cycle %0d outputs=%h", i, obs);
         cyc();
      end
   endtask

   task automatic test_boot();
      bit got, fe; logic [15:0] lo, hi, la; logic ak, sr; int cy;
      idle_inputs(); nmi_i = 1'b0; pc_i = 16'h0000;
      vmem[2] = 8'h00; vmem[3] = 8'h80; ack_delay = 1; rand_delay = 0;
      rst = 1'b0;
      watch_fetch(20, got, lo, hi, la, ak, sr, fe, cy);
      tests_run++;
      if (!got || lo !== 16'hFFFC || hi !== 16'hFFFD || la !== 16'h8000 || ak !== 1'b0 || fe || cy != 5) begin
         tests_failed++;
         $display("FAIL boot: got load=%0d addrs=%h/%h load_addr=%h int_ack=%b fetch_en_seen=%0d at_cycle=%0d required 1 FFFC/FFFD 8000 0 0 5",
                  got, lo, hi, la, ak, fe, cy);
      end
      $display("[TB] boot addrs=%h/%h load_addr=%h int_ack=%b cycle=%0d", lo, hi, la, ak, cy);
      cyc();
      @(negedge clk);
      tests_run++;
      if (fetch_en_o !== 1'b1 || load_pc_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL boot_run: got fetch_en=%b load_pc=%b required 1 0", fetch_en_o, load_pc_o);
      end
      $display("[TB] boot run fetch_en=%b load_pc=%b", fetch_en_o, load_pc_o);
   endtask

   task automatic test_branch();
      cyc();
      branch_req_i = 1'b1; branch_target_i = 16'hC123;
      @(negedge clk);
      tests_run++;
      if (load_pc_o !== 1'b1 || load_addr_o !== 16'hC123 || fetch_en_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL branch: got load_pc=%b addr=%h fetch_en=%b required 1 C123 1", load_pc_o, load_addr_o, fetch_en_o);
      end
      $display("[TB] branch load_pc=%b addr=%h", load_pc_o, load_addr_o);
      for (int i = 0; i < 6; i++) begin
         logic req; logic [15:0] tgt;
         cyc();
         req = (i % 2 == 1) ? 1'b0 : 1'($urandom);
         tgt = 16'($urandom);
         branch_req_i = req; branch_target_i = tgt;
         @(negedge clk);
         tests_run++;
         if (load_pc_o !== req || (req && load_addr_o !== tgt)) begin
            tests_failed++;
            $display("FAIL branch_rand %0d: got load_pc=%b addr=%h required %b %h", i, load_pc_o, load_addr_o, req, tgt);
         end
         $display("[TB] branch %0d req=%b tgt=%h load_pc=%b addr=%h", i, req, tgt, load_pc_o, load_addr_o);
      end
      cyc();
      branch_req_i = 1'b0;
   endtask

   task automatic test_nmi();
      bit got, fe; logic [15:0] lo, hi, la; logic ak, sr; int cy;
      pc_i = 16'h8010; vmem[0] = 8'h34; vmem[1] = 8'h12;
      nmi_i = 1'b1;
      cyc();
      @(negedge clk);
      tests_run++;
      if (vec_req_o !== 1'b0 || fetch_en_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL nmi_wait_boundary: got vec_req=%b fetch_en=%b required 0 1", vec_req_o, fetch_en_o);
      end
      cyc();
      instr_boundary_i = 1'b1;
      @(negedge clk);
      tests_run++;
      if (fetch_en_o !== 1'b1 || load_pc_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL nmi_accept_cycle: got fetch_en=%b load_pc=%b required 1 0", fetch_en_o, load_pc_o);
      end
      cyc();
      instr_boundary_i = 1'b0;
      watch_fetch(30, got, lo, hi, la, ak, sr, fe, cy);
      tests_run++;
      if (!got || lo !== 16'hFFFA || hi !== 16'hFFFB || la !== 16'h1234 || ak !== 1'b1 || sr !== 1'b1 || fe || ret_pc_o !== 16'h8010) begin
         tests_failed++;
         $display("FAIL nmi: got load=%0d addrs=%h/%h load_addr=%h ack=%b src=%b fetch_en_seen=%0d ret=%h required 1 FFFA/FFFB 1234 1 1 0 8010",
                  got, lo, hi, la, ak, sr, fe, ret_pc_o);
      end
      $display("[TB] nmi addrs=%h/%h load_addr=%h ack=%b src=%b ret=%h", lo, hi, la, ak, sr, ret_pc_o);
      cyc();
      instr_boundary_i = 1'b1;
      cyc();
      instr_boundary_i = 1'b0;
      @(negedge clk);
      tests_run++;
      if (vec_req_o !== 1'b0 || fetch_en_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL nmi_pending_cleared: got vec_req=%b fetch_en=%b required 0 1", vec_req_o, fetch_en_o);
      end
      $display("[TB] nmi after-service boundary vec_req=%b", vec_req_o);
   endtask

   task automatic test_irq_mask();
      bit got, fe; logic [15:0] lo, hi, la; logic ak, sr; int cy;
      cyc();
      nmi_i = 1'b0; irq_i = 1'b1; irq_mask_i = 1'b1; pc_i = 16'h8040;
      vmem[4] = 8'h78; vmem[5] = 8'h56;
      for (int i = 0; i < 6; i++) begin
         cyc();
         instr_boundary_i = (i < 5);
         @(negedge clk);
         tests_run++;
         if (vec_req_o !== 1'b0 || fetch_en_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL irq_masked %0d: got vec_req=%b fetch_en=%b required 0 1", i, vec_req_o, fetch_en_o);
         end
         $display("[TB] irq masked cycle %0d vec_req=%b", i, vec_req_o);
      end
      cyc();
      irq_mask_i = 1'b0; instr_boundary_i = 1'b1;
      cyc();
      instr_boundary_i = 1'b0; irq_i = 1'b0;
      watch_fetch(30, got, lo, hi, la, ak, sr, fe, cy);
      tests_run++;
      if (!got || lo !== 16'hFFFE || hi !== 16'hFFFF || la !== 16'h5678 || ak !== 1'b1 || sr !== 1'b0 || ret_pc_o !== 16'h8040) begin
         tests_failed++;
         $display("FAIL irq_unmasked: got load=%0d addrs=%h/%h load_addr=%h ack=%b src=%b ret=%h required 1 FFFE/FFFF 5678 1 0 8040",
                  got, lo, hi, la, ak, sr, ret_pc_o);
      end
      $display("[TB] irq addrs=%h/%h load_addr=%h ack=%b src=%b ret=%h", lo, hi, la, ak, sr, ret_pc_o);
   endtask

   task automatic test_collision();
      bit got, fe; logic [15:0] lo, hi, la; logic ak, sr; int cy;
      cyc();
      nmi_i = 1'b1; pc_i = 16'h8020;
      cyc();
      instr_boundary_i = 1'b1; irq_i = 1'b1; irq_mask_i = 1'b0;
      branch_req_i = 1'b1; branch_target_i = 16'h9000;
      @(negedge clk);
      tests_run++;
      if (load_pc_o !== 1'b1 || load_addr_o !== 16'h9000) begin
         tests_failed++;
         $display("FAIL collision_branch: got load_pc=%b addr=%h required 1 9000", load_pc_o, load_addr_o);
      end
      cyc();
      instr_boundary_i = 1'b0; branch_req_i = 1'b0;
      watch_fetch(30, got, lo, hi, la, ak, sr, fe, cy);
      tests_run++;
      if (!got || lo !== 16'hFFFA || la !== 16'h1234 || ak !== 1'b1 || sr !== 1'b1 || ret_pc_o !== 16'h9000) begin
         tests_failed++;
         $display("FAIL collision_nmi: got load=%0d addr=%h load_addr=%h ack=%b src=%b ret=%h required 1 FFFA 1234 1 1 9000",
                  got, lo, la, ak, sr, ret_pc_o);
      end
      $display("[TB] collision nmi addr=%h src=%b ret=%h", lo, sr, ret_pc_o);
      cyc();
      instr_boundary_i = 1'b1;
      @(negedge clk);
      tests_run++;
      if (fetch_en_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL collision_run_after_load: got fetch_en=%b required 1", fetch_en_o);
      end
      cyc();
      instr_boundary_i = 1'b0; irq_i = 1'b0;
      watch_fetch(30, got, lo, hi, la, ak, sr, fe, cy);
      tests_run++;
      if (!got || lo !== 16'hFFFE || hi !== 16'hFFFF || la !== 16'h5678 || ak !== 1'b1 || sr !== 1'b0 || ret_pc_o !== 16'h8020 || cy != 4) begin
         tests_failed++;
         $display("FAIL collision_irq: got load=%0d addrs=%h/%h load_addr=%h ack=%b src=%b ret=%h cycle=%0d required 1 FFFE/FFFF 5678 1 0 8020 4",
                  got, lo, hi, la, ak, sr, ret_pc_o, cy);
      end
      $display("[TB] collision irq addr=%h src=%b ret=%h cycle=%0d", lo, sr, ret_pc_o, cy);
   endtask

   task automatic test_reset_midfetch();
      bit got, fe, found; logic [15:0] lo, hi, la; logic ak, sr; int cy;
      logic [52:0] obs;
      cyc();
      nmi_i = 1'b0; ack_delay = 3;
      cyc();
      cyc();
      nmi_i = 1'b1;
      cyc();
      instr_boundary_i = 1'b1;
      cyc();
      instr_boundary_i = 1'b0; nmi_i = 1'b0;
      cyc();
      nmi_i = 1'b1;
      found = 0;
      for (int i = 0; i < 30 && !found; i++) begin
         @(negedge clk);
         if (vec_req_o && vec_addr_o == 16'hFFFB) found = 1;
      end
      tests_run++;
      if (!found) begin
         tests_failed++;
         $display("FAIL midfetch_reach_hi: got no request at FFFB required one within 30 cycles");
      end
      rst = 1'b1;
      #1;
      obs = {fetch_en_o, vec_req_o, vec_addr_o, load_pc_o, load_addr_o, int_ack_o, int_src_o, ret_pc_o};
      tests_run++;
      if (obs !== 53'h0) begin
         tests_failed++;
         $display("FAIL midfetch_reset_outputs: got %h required 0", obs);
      end
      $display("[TB] midfetch reset outputs=%h", obs);
      ack_delay = 1; nmi_i = 1'b0;
      cyc(); cyc(); cyc();
      rst = 1'b0;
      watch_fetch(20, got, lo, hi, la, ak, sr, fe, cy);
      tests_run++;
      if (!got || lo !== 16'hFFFC || hi !== 16'hFFFD || la !== 16'h8000 || ak !== 1'b0 || cy != 5) begin
         tests_failed++;
         $display("FAIL midfetch_reboot: got load=%0d addrs=%h/%h load_addr=%h ack=%b cycle=%0d required 1 FFFC/FFFD 8000 0 5",
                  got, lo, hi, la, ak, cy);
      end
      $display("[TB] reboot addrs=%h/%h load_addr=%h ack=%b", lo, hi, la, ak);
      cyc();
      instr_boundary_i = 1'b1;
      cyc();
      instr_boundary_i = 1'b0;
      @(negedge clk);
      tests_run++;
      if (vec_req_o !== 1'b0 || fetch_en_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL midfetch_nmi_discarded: got vec_req=%b fetch_en=%b required 0 1", vec_req_o, fetch_en_o);
      end
   endtask

   // Random run against a reference model built from the sequencer rules:
   // boot fetch, byte-by-byte vector fetch, one load cycle, then running
   // with branch pass-through and interrupt acceptance at boundaries.
   task automatic test_random();
      bit          m_boot, m_fetching, m_load, m_pend, m_nmi_last;
      int          m_kind, m_nbytes, nfail;
      logic [15:0] m_base, m_ret, e_vaddr, e_laddr;
      logic [7:0]  m_lo, m_hi;
      bit          run, e_load, e_iack, e_isrc, rise, take, take_nmi;
      logic [52:0] obs, exp_v;
      rst = 1'b1; rand_delay = 1; idle_inputs(); nmi_i = 1'b0; pc_i = 16'h0;
      for (int i = 0; i < 6; i++) vmem[i] = 8'($urandom);
      cyc(); cyc();
      rst = 1'b0;
      m_boot = 1; m_fetching = 0; m_load = 0; m_pend = 0; m_nmi_last = 0;
      m_kind = 0; m_nbytes = 0; m_base = 16'hFFFC; m_ret = 16'h0; m_lo = 8'h0; m_hi = 8'h0;
      nfail = 0;
      for (int n = 0; n < 1500; n++) begin
         pc_i = 16'($urandom);
         instr_boundary_i = ($urandom_range(0, 3) == 0);
         branch_req_i = ($urandom_range(0, 3) == 0);
         branch_target_i = 16'($urandom);
         if ($urandom_range(0, 7) == 0) nmi_i = ~nmi_i;
         if ($urandom_range(0, 5) == 0) irq_i = ~irq_i;
         if ($urandom_range(0, 5) == 0) irq_mask_i = ~irq_mask_i;
         @(negedge clk);
         run     = !m_boot && !m_fetching && !m_load;
         e_vaddr = m_base + 16'(m_nbytes);
         e_load  = m_load || (run && branch_req_i);
         e_laddr = m_load ? {m_hi, m_lo} : branch_target_i;
         e_iack  = m_load && (m_kind != 0);
         e_isrc  = e_iack && (m_kind == 1);
         exp_v = {run, m_fetching, m_fetching ? e_vaddr : 16'h0, e_load, e_load ? e_laddr : 16'h0,
                  e_iack, e_isrc, m_ret};
         obs   = {fetch_en_o, vec_req_o, m_fetching ? vec_addr_o : 16'h0, load_pc_o,
                  e_load ? load_addr_o : 16'h0, int_ack_o, int_src_o, ret_pc_o};
         tests_run++;
         if (obs !== exp_v) begin
            tests_failed++;
            nfail++;
            $display("FAIL random cycle %0d: got %h required %h", n, obs, exp_v);
         end
         if (e_iack || (n % 100 == 0))
            $display("[TB] random cycle %0d outputs=%h", n, obs);
         // advance the model to the next cycle
         rise = nmi_i && !m_nmi_last;
         m_nmi_last = nmi_i;
         if (m_boot) begin
            m_boot = 0; m_fetching = 1; m_kind = 0; m_base = 16'hFFFC; m_nbytes = 0;
         end else begin
            take     = run && instr_boundary_i && (m_pend || (irq_i && !irq_mask_i));
            take_nmi = take && m_pend;
            if (rise) m_pend = 1;
            else if (take_nmi) m_pend = 0;
            if (m_fetching) begin
               if (vec_ack_i) begin
                  if (m_nbytes == 0) m_lo = mem_byte(e_vaddr);
                  else m_hi = mem_byte(e_vaddr);
                  m_nbytes++;
                  if (m_nbytes == 2) begin
                     m_fetching = 0; m_load = 1;
                  end
               end
            end else if (m_load) begin
               m_load = 0;
            end else if (take) begin
               m_fetching = 1; m_nbytes = 0;
               m_kind = take_nmi ? 1 : 2;
               m_base = take_nmi ? 16'hFFFA : 16'hFFFE;
               m_ret  = branch_req_i ? branch_target_i : pc_i;
            end
         end
         cyc();
      end
      $display("[TB] random run done, %0d cycle mismatches", nfail);
      rand_delay = 0;
   endtask

   initial begin
      test_reset();
      test_boot();
      test_branch();
      test_nmi();
      test_irq_mask();
      test_collision();
      test_reset_midfetch();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/pc_seq_ctrl.md
Name: pc_seq_ctrl

Overview:
- Sequencer that owns all non-sequential updates of the program-counter register.
- At boot it fetches the 6502 reset vector and loads it into the PC.
- In run mode it forwards execute-stage branch redirects.
- At instruction boundaries it accepts NMI/IRQ, fetches the matching vector and redirects the PC.
- Sits between the execute stage, the interrupt lines, the memory read port and the PC register's taken_branch/new_pc inputs.

Parameters:
ADDR_W, 16, PC / memory address width
RESET_VEC, 16'hFFFC, low-byte address of the reset vector
NMI_VEC, 16'hFFFA, low-byte address of the NMI vector
IRQ_VEC, 16'hFFFE, low-byte address of the IRQ/BRK vector

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
pc_i  in  ADDR_W  current PC register value
instr_boundary_i  in  1  current instruction retires this cycle
branch_req_i  in  1  execute requests PC redirect
branch_target_i  in  ADDR_W  redirect target
nmi_i  in  1  NMI line, rising-edge triggered, synchronous to clk
irq_i  in  1  IRQ line, level-sensitive, active-high
irq_mask_i  in  1  processor I flag; 1 blocks IRQ
vec_req_o  out  1  vector byte read request
vec_addr_o  out  ADDR_W  vector byte address
vec_data_i  in  8  read data, valid when vec_ack_i=1
vec_ack_i  in  1  read completes this cycle
load_pc_o  out  1  to PC taken_branch input
load_addr_o  out  ADDR_W  to PC new_pc input
fetch_en_o  out  1  core may fetch/execute
int_ack_o  out  1  one-cycle pulse: interrupt vector loaded
int_src_o  out  1  0=IRQ, 1=NMI; valid with int_ack_o
ret_pc_o  out  ADDR_W  return address captured at interrupt acceptance, for core push

Behaviour:
- FSM states: BOOT, VEC_LO, VEC_HI, LOAD, RUN.
- Reset: state=BOOT, vec_sel=RESET, nmi_pending=0, nmi_prev=0, ret_pc=0, vector byte regs=0.
  - All outputs 0 while rst=1.
  - In reset, every output decode from state yields 0; load_addr_o=0.
- BOOT -> VEC_LO unconditionally on the first clk edge after rst deasserts.
- VEC_LO:
  - vec_req_o=1, vec_addr_o=base (RESET_VEC/NMI_VEC/IRQ_VEC per vec_sel).
  - Request and address held stable until vec_ack_i=1; that cycle capture lo=vec_data_i, go to VEC_HI.
  - Ack may come the same cycle as request; there is no timeout.
- VEC_HI:
  - Same handshake with vec_addr_o=base+1 (ADDR_W-bit wrap); capture hi.
  - Go to LOAD.
- LOAD (exactly one cycle):
  - load_pc_o=1, load_addr_o={hi,lo}.
  - If vec_sel!=RESET: int_ack_o=1, int_src_o=(vec_sel==NMI).
  - Go to RUN.
- RUN:
  - fetch_en_o=1.
  - load_pc_o=branch_req_i and load_addr_o=branch_target_i, combinational, zero latency.
  - branch_req_i is ignored in every other state.
- Output decode: fetch_en_o=1 only in RUN. vec_req_o=1 only in VEC_LO/VEC_HI. int_ack_o=1 only in LOAD.
- NMI detection:
  - nmi_prev registers nmi_i each cycle.
  - A rising edge (nmi_i & ~nmi_prev) sets nmi_pending in any state except BOOT.
  - nmi_pending clears when NMI is accepted.
  - An edge in the same cycle as acceptance stays pending (set wins).
- Acceptance (RUN only, instr_boundary_i=1):
  - nmi_pending=1 -> vec_sel=NMI.
  - Else irq_i & ~irq_mask_i -> vec_sel=IRQ.
  - Else no action.
  - Priority: NMI > IRQ; reset overrides everything.
  - On acceptance: ret_pc_o <= branch_req_i ? branch_target_i : pc_i. The branch load still occurs that cycle. Next state VEC_LO.
- ret_pc_o holds its value until the next acceptance.
- IRQ is not latched. If deasserted or masked before a boundary, it is not taken.
- Interrupts arriving during VEC_LO/VEC_HI/LOAD are not serviced until the next RUN boundary. The first boundary can occur the cycle after LOAD.
- rst mid-fetch: immediate return to BOOT, pending NMI discarded, boot sequence restarts with RESET_VEC.

Test Plan:
1. Boot: rst held 10 cycles; memory acks 1 cycle after request with FFFC=0x00, FFFD=0x80 -> vec_addr_o 0xFFFC then 0xFFFD; single load_pc_o pulse, load_addr_o=0x8000, int_ack_o=0; fetch_en_o=1 from next cycle.
2. Branch: in RUN drive branch_req_i=1, branch_target_i=0xC123 for one cycle -> same-cycle load_pc_o=1, load_addr_o=0xC123; no load when branch_req_i=0.
3. NMI: rising edge on nmi_i, then instr_boundary_i with pc_i=0x8010; vector FFFA=0x34, FFFB=0x12 -> ret_pc_o=0x8010, fetch_en_o=0 during fetch, load_addr_o=0x1234, int_ack_o=1, int_src_o=1; nmi_pending cleared.
4. Masked IRQ: irq_i=1, irq_mask_i=1 over 5 boundaries -> no vec_req_o; drop mask -> next boundary fetches 0xFFFE/0xFFFF, int_src_o=0.
5. Collision: NMI pending and IRQ unmasked at a boundary with branch_req_i=1, target 0x9000 -> load_pc_o=1 to 0x9000, NMI serviced, ret_pc_o=0x9000; IRQ serviced at first boundary after LOAD if irq_i still 1.
6. Reset mid-fetch: assert rst while in VEC_HI of an NMI with ack delayed 3 cycles -> all outputs 0 immediately; after release, boot re-runs from 0xFFFC; no int_ack_o.
